vector_u_loader: RTL and testbench
==================================

Name: vector_u_loader

Overview:
- Upstream feeder for the 256-bit URAM vector store (vector_U).
- Accepts a 32-bit word stream with a valid/ready handshake and packs 8 words into one 256-bit vector.
- Writes each packed vector to consecutive 6-bit URAM addresses.
- After the programmed number of vectors is written, issues a one-cycle read trigger that drives the store's en_read.

Parameters:
- WORD_W, 32, input word width.
- VEC_W, 256, packed vector width; must be an integer multiple of WORD_W.
- ADDR_W, 6, URAM address width (64 entries).
- LANES, VEC_W/WORD_W (8), words per vector; derived, not overridable.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load job.
- base_addr  in  ADDR_W  first URAM address of the job; sampled on an accepted start.
- num_vec  in  ADDR_W+1  number of vectors to load (1..64); sampled on an accepted start.
- s_data  in  WORD_W  stream word.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a word this cycle.
- wr_data  out  VEC_W  packed vector to the store's data_in.
- wr_addr  out  ADDR_W  store address.
- wr_en  out  1  write strobe, one cycle per vector.
- rd_trigger  out  1  one-cycle pulse to the store's en_read after the job completes.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse, coincident with rd_trigger.

Behaviour:
- Reset: all outputs are 0; state is IDLE; lane, address and vector counters are 0; a partially packed vector is discarded.
- Reset asserted mid-job aborts the job; no wr_en or rd_trigger follows.
- Handshake: a word transfers on a rising edge with s_valid && s_ready. s_ready is combinational from state only, never from s_valid.
- FSM IDLE:
  - busy=0, s_ready=0.
  - start with num_vec in 1..64: latch base_addr into the address counter, latch num_vec, clear counters, go to PACK.
  - start with num_vec=0: ignored, remain in IDLE.
  - num_vec>64: clamped to 64.
- FSM PACK:
  - busy=1, s_ready=1.
  - Accepted word k (k=0..7) lands in bits [32k+31:32k] of the pack register; word 0 is the LSB.
  - Acceptance of word 7 moves the FSM to WRITE.
  - Cycles with s_valid=0 insert bubbles with no state change.
- FSM WRITE (exactly one cycle):
  - s_ready=0; wr_en=1; wr_data=pack register; wr_addr=address counter.
  - Then: address counter +1 (wraps 63 to 0), vector counter +1.
  - If vector counter == num_vec, go to FIN; otherwise go to PACK with the lane counter at 0.
- FSM FIN (exactly one cycle): rd_trigger=1, done=1, busy=1; then IDLE.
- Latency: wr_en asserts the cycle after the 8th word is accepted. rd_trigger asserts the cycle after the final wr_en.
- Sustained throughput: 8 words per 9 cycles.
- wr_data and wr_addr hold their last written values outside WRITE. They are 0 after reset.
- start while busy=1 is ignored. base_addr and num_vec changes during a job have no effect.
- Address wrap: base_addr=62, num_vec=4 writes addresses 62, 63, 0, 1.
- s_data is ignored whenever s_ready=0.

Test Plan:
- Reset, then start with base_addr=1, num_vec=1; stream words 0x00000000..0x00000007 with s_valid held high -> exactly one wr_en, wr_addr=1, wr_data=0x00000007_00000006_..._00000000; rd_trigger and done pulse exactly 1 cycle later; busy returns to 0.
- num_vec=4, base_addr=62, continuous stream of 32 words -> wr_en at addresses 62, 63, 0, 1, each 9 cycles apart; a single rd_trigger after the 4th write.
- Random s_valid gaps (~50% duty), num_vec=2 -> packed data is identical to the gap-free case; s_ready never depends on s_valid; no word is lost or duplicated.
- start with num_vec=0 -> busy stays 0, s_ready stays 0, no wr_en. A second start pulse mid-job -> ignored; the job completes with its original parameters.
- rst asserted after 5 words of a num_vec=2 job -> next cycle all outputs are 0 and state is IDLE. A fresh job with num_vec=1 then writes only the new 8 words; no stale lanes appear.
- num_vec=64 from base_addr=0 -> 64 writes covering every address 0..63 exactly once, then one rd_trigger.

Source files
------------

// File: rtl/vector_u_loader.sv
// vector_u_loader
// ---------------
// Packs a stream of WORD_W-bit words into VEC_W-bit vectors and writes them to
// consecutive addresses of the URAM vector store. When the programmed number
// of vectors has been written, it pulses rd_trigger (the store's en_read)
// together with done.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         one-cycle job start pulse (honoured only when idle)
//   base_addr     first store address of the job (sampled on accepted start)
//   num_vec       vectors to load, 1..2**ADDR_W; larger values are clamped
//   s_data/s_valid/s_ready   word stream handshake
//   wr_data/wr_addr/wr_en    store write port
//   rd_trigger    one-cycle pulse after the final write
//   busy          job in progress
//   done          one-cycle pulse, coincident with rd_trigger
module vector_u_loader #(
  parameter  int WORD_W = 32,
  parameter  int VEC_W  = 256,
  parameter  int ADDR_W = 6,
  localparam int LANES  = VEC_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_vec,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [VEC_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              rd_trigger,
  output logic              busy,
  output logic              done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  // Store depth, i.e. the largest meaningful vector count.
  localparam logic [ADDR_W:0] MAX_VEC = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, PACK, WRITE, FIN} state_t;

  state_t             state_reg, state_next;
  logic [LANE_W-1:0]  lane_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [ADDR_W:0]    vec_cnt_reg;
  logic [ADDR_W:0]    num_reg;
  logic [VEC_W-1:0]   pack_reg;
  logic [VEC_W-1:0]   wr_data_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [VEC_W-1:0]   pack_merged;
  logic [ADDR_W:0]    vec_cnt_inc;
  logic               start_ok;
  logic               word_acc;

  assign start_ok    = start && (num_vec != '0);
  assign word_acc    = (state_reg == PACK) && s_valid;
  assign vec_cnt_inc = vec_cnt_reg + 1'b1;

  // Pack register with the current lane replaced by the incoming word. On the
  // last lane this is the complete vector, so it can be captured straight into
  // the write-data register and presented during the WRITE cycle.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign pack_merged[gi*WORD_W +: WORD_W] =
        (lane_reg == LANE_W'(gi)) ? s_data : pack_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    wr_en      = 1'b0;
    rd_trigger = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_next = PACK;
      end
      PACK: begin
        s_ready = 1'b1;
        if (s_valid && lane_reg == LAST_LANE) state_next = WRITE;
      end
      WRITE: begin
        wr_en      = 1'b1;
        state_next = (vec_cnt_inc == num_reg) ? FIN : PACK;
      end
      FIN: begin
        rd_trigger = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_reg    <= '0;
      addr_reg    <= '0;
      vec_cnt_reg <= '0;
      num_reg     <= '0;
      pack_reg    <= '0;
      wr_data_reg <= '0;
      wr_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            addr_reg    <= base_addr;
            num_reg     <= (num_vec > MAX_VEC) ? MAX_VEC : num_vec;
            vec_cnt_reg <= '0;
            lane_reg    <= '0;
          end
        end
        PACK: begin
          if (word_acc) begin
            pack_reg <= pack_merged;
            if (lane_reg == LAST_LANE) begin
              lane_reg    <= '0;
              wr_data_reg <= pack_merged;
              wr_addr_reg <= addr_reg;
            end else begin
              lane_reg <= lane_reg + 1'b1;
            end
          end
        end
        WRITE: begin
          // Address wraps naturally at the top of the store.
          addr_reg    <= addr_reg + 1'b1;
          vec_cnt_reg <= vec_cnt_inc;
          lane_reg    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign wr_data = wr_data_reg;
  assign wr_addr = wr_addr_reg;

endmodule

// File: tb/tb_vector_u_loader.sv
module tb_vector_u_loader;
  localparam int WORD_W = 32;
  localparam int VEC_W  = 256;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_vec;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [VEC_W-1:0]  wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              rd_trigger;
  logic              busy;
  logic              done;

  vector_u_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_vec(num_vec), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_trigger(rd_trigger), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [VEC_W-1:0]  data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   last_wr_cyc = -1;
  bit   chk_spacing = 0;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every write is popped against the expected queue.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      total_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_wr: got write addr=%0d, required no write", wr_addr);
      end else begin
        mon_e = sb_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data)
          $display("FAIL wr_vec: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        else pass_cnt++;
      end
      if (chk_spacing && last_wr_cyc >= 0) begin
        total_cnt++;
        if (cyc - last_wr_cyc != 9)
          $display("FAIL wr_spacing: got %0d cycles, required 9", cyc - last_wr_cyc);
        else pass_cnt++;
      end
      last_wr_cyc = cyc;
      wr_cnt++;
      $display("[%0d] write addr=%0d data=%h", cyc, wr_addr, wr_data);
    end
    if (rd_trigger === 1'b1 || done === 1'b1) begin
      total_cnt++;
      if (rd_trigger !== 1'b1 || done !== 1'b1 || busy !== 1'b1 || last_wr_cyc != cyc - 1)
        $display("FAIL rd_pulse: got rd=%b done=%b busy=%b gap=%0d, required 1 1 1 gap=1",
                 rd_trigger, done, busy, cyc - last_wr_cyc);
      else pass_cnt++;
      rd_cnt++;
      $display("[%0d] rd_trigger", cyc);
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    start = 1'b1; base_addr = b; num_vec = n;
    @(posedge clk); #1;
    start = 1'b0;
    // Parameter inputs change after start; the job must not notice.
    base_addr = ADDR_W'($urandom); num_vec = (ADDR_W+1)'($urandom);
  endtask

  // Feeds words wbase+0, wbase+1, ... ; gap_pct percent of cycles idle.
  task automatic feed(input int n_words, input logic [31:0] wbase, input int gap_pct,
                      input int inject_at, input bit check_indep);
    int   sent;
    int   budget;
    bit   injected;
    logic r0, r1;
    sent = 0; budget = n_words * 20 + 50; injected = 0;
    while (sent < n_words && budget > 0) begin
      r0 = s_ready;
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? wbase + sent : 32'hDEAD_BEEF;
      if (!injected && inject_at == sent) begin
        start = 1'b1; base_addr = 6'd40; num_vec = 7'd3; injected = 1;
      end else begin
        start = 1'b0;
      end
      #1;
      r1 = s_ready;
      if (check_indep) begin
        total_cnt++;
        if (r1 !== r0) $display("FAIL ready_indep: got s_ready=%b after s_valid change, required %b", r1, r0);
        else pass_cnt++;
      end
      @(posedge clk);
      if (s_valid && r1) sent++;
      #1;
      budget--;
    end
    s_valid = 1'b0; start = 1'b0; s_data = 32'hDEAD_BEEF;
    if (sent < n_words) begin
      total_cnt++;
      $display("FAIL feed_timeout: got %0d words accepted, required %0d", sent, n_words);
    end
  endtask

  task automatic run_job(input int b, input int n_in, input logic [31:0] wbase,
                         input int gap_pct, input bit spacing, input int inject_at);
    int   n, wr0, rd0, tmo;
    exp_t e;
    n = (n_in > 64) ? 64 : n_in;
    wr0 = wr_cnt; rd0 = rd_cnt;
    for (int v = 0; v < n; v++) begin
      e.addr = ADDR_W'(b + v);
      for (int l = 0; l < 8; l++) e.data[l*32 +: 32] = wbase + 32'(v*8 + l);
      sb_q.push_back(e);
    end
    chk_spacing = spacing; last_wr_cyc = -1;
    pulse_start(ADDR_W'(b), (ADDR_W+1)'(n_in));
    feed(n * 8, wbase, gap_pct, inject_at, gap_pct > 0);
    tmo = 40;
    while (rd_cnt == rd0 && tmo > 0) begin @(posedge clk); tmo--; end
    repeat (3) @(posedge clk);
    #1;
    chk_spacing = 0;
    total_cnt++;
    if (wr_cnt - wr0 != n || rd_cnt - rd0 != 1 || sb_q.size() != 0)
      $display("FAIL job_counts: got writes=%0d rd=%0d left=%0d, required writes=%0d rd=1 left=0",
               wr_cnt - wr0, rd_cnt - rd0, sb_q.size(), n);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL job_idle: got busy=%b s_ready=%b, required 0 0", busy, s_ready);
    else pass_cnt++;
    sb_q.delete();
    $display("job base=%0d num=%0d gaps=%0d%% finished", b, n_in, gap_pct);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, s_ready, wr_en, rd_trigger, done} !== 5'b0 || wr_data !== '0 || wr_addr !== '0)
      $display("FAIL reset_outs: got ctl=%b addr=%0d data=%h, required all 0",
               {busy, s_ready, wr_en, rd_trigger, done}, wr_addr, wr_data);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();  run_job(1, 1, 32'h0, 0, 0, -1);      endtask
  task automatic test_wrap();    run_job(62, 4, 32'h100, 0, 1, -1);  endtask
  task automatic test_gaps();
    run_job(5, 2, 32'h200, 0, 1, -1);
    run_job(5, 2, 32'h200, 50, 0, -1);
  endtask

  task automatic test_zero_start();
    int rd0;
    rd0 = rd_cnt;
    pulse_start(6'd7, 7'd0);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 32'h5555_0000 + i;
      @(posedge clk); #1;
      total_cnt++;
      if (busy !== 1'b0 || s_ready !== 1'b0)
        $display("FAIL zero_num: got busy=%b s_ready=%b, required 0 0", busy, s_ready);
      else pass_cnt++;
    end
    s_valid = 1'b0;
    total_cnt++;
    if (rd_cnt != rd0) $display("FAIL zero_rd: got %0d triggers, required 0", rd_cnt - rd0);
    else pass_cnt++;
  endtask

  task automatic test_restart_ignored(); run_job(30, 2, 32'h300, 0, 1, 4); endtask

  task automatic test_abort();
    int wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    pulse_start(6'd20, 7'd2);
    feed(5, 32'hBAD0_0000, 0, -1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, s_ready, wr_en, rd_trigger, done} !== 5'b0 || wr_data !== '0 || wr_addr !== '0)
      $display("FAIL abort_outs: got ctl=%b addr=%0d data=%h, required all 0",
               {busy, s_ready, wr_en, rd_trigger, done}, wr_addr, wr_data);
    else pass_cnt++;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    total_cnt++;
    if (wr_cnt != wr0 || rd_cnt != rd0)
      $display("FAIL abort_quiet: got writes=%0d rd=%0d, required 0 0", wr_cnt - wr0, rd_cnt - rd0);
    else pass_cnt++;
    run_job(20, 1, 32'hA000_0000, 0, 0, -1);
  endtask

  task automatic test_full();  run_job(0, 64, 32'h1000, 0, 1, -1);   endtask
  task automatic test_clamp(); run_job(10, 100, 32'h8000, 0, 1, -1); endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0;
    s_data = '0; s_valid = 1'b0;
    #1;
    test_reset();
    test_single();
    test_wrap();
    test_gaps();
    test_zero_start();
    test_restart_ignored();
    test_abort();
    test_full();
    test_clamp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end
endmodule
